// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit. A WIDTH-bit operation is split into STAGES
// chunks of CW bits. Stage k adds chunk k and registers its carry for stage
// k+1. Untouched operand chunks and finished sum chunks travel with the
// operation, so every chunk lines up at the output. A single advance signal
// moves or stalls the whole pipeline, which gives valid/ready backpressure.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Stage register k holds the operation after chunk k has been added.
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic [WIDTH-1:0]  r_x   [STAGES];
  logic [WIDTH-1:0]  r_y   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic              r_overflow;
  logic              r_zero;

  // Inputs seen by each stage, and the values that stage produces.
  logic              w_advance;
  logic [STAGES-1:0] w_valid_src;
  logic [STAGES-1:0] w_carry_src;
  logic [STAGES-1:0] w_carry_nxt;
  logic [WIDTH-1:0]  w_x_src   [STAGES];
  logic [WIDTH-1:0]  w_y_src   [STAGES];
  logic [WIDTH-1:0]  w_sum_src [STAGES];
  logic [WIDTH-1:0]  w_sum_nxt [STAGES];
  logic [CW:0]       w_chunk   [STAGES];
  logic              w_overflow_nxt;
  logic              w_zero_nxt;

  // The pipeline moves only when the output slot is empty or is being drained.
  assign w_advance = !r_valid[LAST] || out_ready;
  assign in_ready  = w_advance;

  // Select each stage's inputs. Stage 0 takes the ports, and subtraction is
  // folded in as an inverted y plus an inverted carry-in.
  always_comb begin
    w_valid_src[0] = in_valid;
    w_x_src[0]     = x;
    w_y_src[0]     = y ^ {WIDTH{sub}};
    w_carry_src[0] = cin ^ sub;
    w_sum_src[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_valid_src[k] = r_valid[k-1];
      w_x_src[k]     = r_x[k-1];
      w_y_src[k]     = r_y[k-1];
      w_carry_src[k] = r_carry[k-1];
      w_sum_src[k]   = r_sum[k-1];
    end
  end

  // Each stage does one CW-bit add and writes the new chunk into the
  // partial sum it passes on.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_chunk[k]     = {1'b0, w_x_src[k][k*CW +: CW]}
                     + {1'b0, w_y_src[k][k*CW +: CW]}
                     + {{CW{1'b0}}, w_carry_src[k]};
      w_carry_nxt[k] = w_chunk[k][CW];
      // NOTE: copy the full word first, then overwrite one chunk. Every bit is
      // assigned on every pass, so no latch is inferred.
      w_sum_nxt[k]   = w_sum_src[k];
      w_sum_nxt[k][k*CW +: CW] = w_chunk[k][CW-1:0];
    end
  end

  // Compute the flags from the final stage's complete sum so they are
  // registered together with it.
  always_comb begin
    w_zero_nxt     = ~|w_sum_nxt[LAST];
    w_overflow_nxt = (w_x_src[LAST][WIDTH-1] == w_y_src[LAST][WIDTH-1]) &&
                     (w_sum_nxt[LAST][WIDTH-1] != w_x_src[LAST][WIDTH-1]);
  end

  // Shift every stage forward together on advance. Otherwise hold. Reset
  // clears all stages, so in-flight work is discarded at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= '0;
      r_carry    <= '0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      // NOTE: these stage arrays are flops, not RAM, so they are reset along
      // with the valid bits. The held result then reads as 0 after reset.
      for (int k = 0; k < STAGES; k++) begin
        r_x[k]   <= '0;
        r_y[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else if (w_advance) begin
      // NOTE: non-blocking updates let every stage sample the previous
      // stage's old value on the same edge.
      r_valid    <= w_valid_src;
      r_carry    <= w_carry_nxt;
      r_overflow <= w_overflow_nxt;
      r_zero     <= w_zero_nxt;
      for (int k = 0; k < STAGES; k++) begin
        r_x[k]   <= w_x_src[k];
        r_y[k]   <= w_y_src[k];
        r_sum[k] <= w_sum_nxt[k];
      end
    end
  end

  assign out_valid = r_valid[LAST];
  assign sum       = r_sum[LAST];
  assign carry     = r_carry[LAST];
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder. Directed vectors run on a 32-bit/4-stage
// instance. Random operations are checked against a full-width reference
// model on (16,1), (16,4) and (64,8) instances.
module tb_pipelined_adder;

  localparam int N_SW = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Main instance, default parameters.
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        cin, sub, carry, overflow, zero;
  logic [31:0] x, y, sum;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry(carry), .overflow(overflow),
    .zero(zero)
  );

  // Sweep instances share one stimulus bus.
  logic        sw_valid, sw_cin, sw_sub;
  logic [63:0] sw_x, sw_y;
  logic        rdy_a, v_a, c_a, o_a, z_a;
  logic        rdy_b, v_b, c_b, o_b, z_b;
  logic        rdy_c, v_c, c_c, o_c, z_c;
  logic [15:0] s_a, s_b;
  logic [63:0] s_c;

  pipelined_adder #(.WIDTH(16), .STAGES(1)) u_sw_a (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy_a),
    .x(sw_x[15:0]), .y(sw_y[15:0]), .cin(sw_cin), .sub(sw_sub),
    .out_valid(v_a), .out_ready(1'b1), .sum(s_a), .carry(c_a),
    .overflow(o_a), .zero(z_a)
  );

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_sw_b (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy_b),
    .x(sw_x[15:0]), .y(sw_y[15:0]), .cin(sw_cin), .sub(sw_sub),
    .out_valid(v_b), .out_ready(1'b1), .sum(s_b), .carry(c_b),
    .overflow(o_b), .zero(z_b)
  );

  pipelined_adder #(.WIDTH(64), .STAGES(8)) u_sw_c (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy_c),
    .x(sw_x), .y(sw_y), .cin(sw_cin), .sub(sw_sub),
    .out_valid(v_c), .out_ready(1'b1), .sum(s_c), .carry(c_c),
    .overflow(o_c), .zero(z_c)
  );

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic        cin;
    logic        sub;
    int          issue;
  } op_t;

  op_t ops [N_SW];
  int  head [3];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one full-width add, masked to w bits.
  // Returns {overflow, carry, sum}.
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic ci, input logic s);
    logic [63:0] mask, aa, bb, r;
    logic [64:0] full;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = a & mask;
    bb   = (b ^ {64{s}}) & mask;
    full = {1'b0, aa} + {1'b0, bb} + {64'd0, ci ^ s};
    r    = full[63:0] & mask;
    return {(aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]), full[w], r};
  endfunction

  // One operation through an empty pipeline with out_ready=1. Checks the
  // latency and all result fields.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic s, input logic [31:0] es,
                         input logic ec, input logic eo, input logic ez);
    int n;
    @(negedge clk);
    in_valid = 1'b1; x = a; y = b; cin = ci; sub = s;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_latency", tag), n, 4);
    check($sformatf("%s_sum", tag), sum, es);
    check($sformatf("%s_carry", tag), carry, ec);
    check($sformatf("%s_overflow", tag), overflow, eo);
    check($sformatf("%s_zero", tag), zero, ez);
  endtask

  task automatic sw_check(input int c, input int w, input int s, input logic v, input logic rdy,
                          input logic [63:0] sm, input logic cr, input logic ov, input logic zr);
    logic [65:0] r;
    check($sformatf("sw%0d_in_ready", c), rdy, 1'b1);
    if (v) begin
      if (head[c] >= N_SW) begin
        check($sformatf("sw%0d_extra_result", c), v, 1'b0);
      end else begin
        r = ref_add(w, ops[head[c]].x, ops[head[c]].y, ops[head[c]].cin, ops[head[c]].sub);
        check($sformatf("sw%0d_op%0d_result", c, head[c]), {ov, cr, zr, sm},
              {r[65], r[64], r[63:0] == 64'd0, r[63:0]});
        check($sformatf("sw%0d_op%0d_latency", c, head[c]), cyc - ops[head[c]].issue, s);
        head[c]++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          tx, rx, hold;
    logic        seen, snapped;
    logic [34:0] snap;

    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_x = '0; sw_y = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    head[0] = 0; head[1] = 0; head[2] = 0;
    snap = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_sum", sum, 32'd0);
    check("reset_flags", {carry, overflow, zero}, 3'b000);
    rst_n = 1'b1;

    // Directed arithmetic
    run_one("chunk_carry", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
    run_one("full_wrap",   32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_one("sub_neg",     32'd5,        32'd7,        1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_one("sub_ovf",     32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    run_one("add_ovf",     32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_one("sub_borrow",  32'd10,       32'd3,        1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("drained_out_valid", out_valid, 1'b0);

    // Streaming with a 3-cycle hold starting at the first valid result
    tx = 0; rx = 0; hold = 0; seen = 1'b0; snapped = 1'b0;
    for (int t = 0; t < 60 && rx < 8; t++) begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1'b1;
        hold = 3;
      end
      if (hold > 0) begin
        out_ready = 1'b0;
        hold--;
        #1;
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        if (snapped) check("bp_stable", {sum, carry, overflow, zero}, snap);
        snap    = {sum, carry, overflow, zero};
        snapped = 1'b1;
      end else begin
        out_ready = 1'b1;
        #1;
      end
      if (out_valid && out_ready) begin
        check($sformatf("stream_result%0d", rx), sum, 2 * rx);
        rx++;
      end
      if (in_ready && tx < 8) begin
        in_valid = 1'b1; x = tx; y = tx; cin = 1'b0; sub = 1'b0;
        tx++;
      end else begin
        in_valid = 1'b0;
      end
    end
    check("stream_count", rx, 8);
    @(negedge clk);
    check("stream_no_extra", out_valid, 1'b0);

    // Reset while operations are in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = 100 + i; y = 1; cin = 1'b0; sub = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("midrst_pre_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sum", sum, 32'd0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("postrst_idle%0d", i), out_valid, 1'b0);
    end
    run_one("postrst_op", 32'd7, 32'd8, 1'b0, 1'b0, 32'd15, 1'b0, 1'b0, 1'b0);

    // Parameter sweep against the reference model
    for (int t = 0; t < N_SW + 12; t++) begin
      @(negedge clk);
      sw_check(0, 16, 1, v_a, rdy_a, 64'(s_a), c_a, o_a, z_a);
      sw_check(1, 16, 4, v_b, rdy_b, 64'(s_b), c_b, o_b, z_b);
      sw_check(2, 64, 8, v_c, rdy_c, s_c, c_c, o_c, z_c);
      if (t < N_SW) begin
        ops[t].x     = {$urandom, $urandom};
        ops[t].y     = {$urandom, $urandom};
        ops[t].cin   = 1'($urandom_range(1));
        ops[t].sub   = 1'($urandom_range(1));
        ops[t].issue = cyc;
        sw_x = ops[t].x; sw_y = ops[t].y; sw_cin = ops[t].cin; sw_sub = ops[t].sub;
        sw_valid = 1'b1;
      end else begin
        sw_valid = 1'b0;
      end
    end
    check("sw0_count", head[0], N_SW);
    check("sw1_count", head[1], N_SW);
    check("sw2_count", head[2], N_SW);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
